fetch_ctrl: RTL and testbench

// - Instruction-fetch controller for the MIPS32 IF stage; owns the program counter and the chip-enable.
// - Sequences the PC through a req/ack instruction-memory handshake, holds it on pipeline stall, and redirects it on branch.
// - Delivers {if_pc, if_inst, if_valid} to the IF/ID register.

---
 rtl/fetch_ctrl_if.sv | 21 ++
 rtl/fetch_ctrl.sv | 176 +++++++++++++++++
 tb/tb_fetch_ctrl.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_ctrl_if.sv
// Instruction-memory request/acknowledge bus between fetch_ctrl and the imem.
interface fetch_ctrl_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_rdata
  );
endinterface

// File: rtl/fetch_ctrl.sv
// MIPS32 IF-stage fetch controller: owns the PC, runs the imem req/ack handshake, stalls and redirects.
// Optional FETCH_TIMEOUT_EN adds an ack-wait timeout that raises fetch_err and retries from IDLE.
module fetch_ctrl #(
  parameter logic [31:0] RESET_VECTOR   = 32'h0000_0000,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         stall,
  input  logic         branch_flag,
  input  logic [31:0]  branch_target,
  fetch_ctrl_if.master imem,
  output logic         ce,
  output logic [31:0]  if_pc,
  output logic [31:0]  if_inst,
  output logic         if_valid
`ifdef FETCH_TIMEOUT_EN
  ,
  output logic         fetch_err
`endif
);

  typedef enum logic [1:0] {IDLE, FETCH, HOLD} state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        req_q, req_d;
  logic        ce_q, ce_d;
  logic [31:0] ifpc_q, ifpc_d;
  logic [31:0] ifinst_q, ifinst_d;
  logic        ifv_q, ifv_d;
  logic        pend_q, pend_d;
  logic [31:0] tgt_q, tgt_d;
  logic [31:0] buf_q, buf_d;
  logic        bufv_q, bufv_d;
`ifdef FETCH_TIMEOUT_EN
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);
  logic [7:0]  cnt_q, cnt_d;
  logic        err_q, err_d;
`endif

  logic [31:0] br_tgt;
  assign br_tgt = {branch_target[31:2], 2'b00};

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    req_d    = req_q;
    ifpc_d   = ifpc_q;
    ifinst_d = ifinst_q;
    ifv_d    = 1'b0;
    pend_d   = pend_q;
    tgt_d    = tgt_q;
    buf_d    = buf_q;
    bufv_d   = bufv_q;
`ifdef FETCH_TIMEOUT_EN
    cnt_d    = cnt_q;
    err_d    = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (branch_flag) pc_d = br_tgt;
        state_d = FETCH;
        req_d   = 1'b1;
      end
      FETCH: begin
        if (imem.imem_ack) begin
`ifdef FETCH_TIMEOUT_EN
          cnt_d = '0;
`endif
          if (branch_flag) begin
            pc_d   = br_tgt;
            pend_d = 1'b0;
          end else if (pend_q) begin
            pc_d   = tgt_q;
            pend_d = 1'b0;
          end else if (stall) begin
            // PC stays put while held; it doubles as the buffered fetch address
            buf_d   = imem.imem_rdata;
            bufv_d  = 1'b1;
            req_d   = 1'b0;
            state_d = HOLD;
          end else begin
            ifv_d    = 1'b1;
            ifpc_d   = pc_q;
            ifinst_d = imem.imem_rdata;
            pc_d     = pc_q + 32'd4;
          end
        end else begin
          if (branch_flag) begin
            pend_d = 1'b1;
            tgt_d  = br_tgt;
          end
`ifdef FETCH_TIMEOUT_EN
          if (cnt_q == TO_LAST) begin
            cnt_d   = '0;
            req_d   = 1'b0;
            err_d   = 1'b1;
            state_d = IDLE;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
`endif
        end
      end
      HOLD: begin
        if (branch_flag) begin
          pc_d   = br_tgt;
          bufv_d = 1'b0;
        end else if (!stall) begin
          state_d = FETCH;
          req_d   = 1'b1;
          bufv_d  = 1'b0;
          if (bufv_q) begin
            ifv_d    = 1'b1;
            ifpc_d   = pc_q;
            ifinst_d = buf_q;
            pc_d     = pc_q + 32'd4;
          end
        end
      end
      default: begin
        state_d = IDLE;
        req_d   = 1'b0;
      end
    endcase
    ce_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      pc_q     <= RESET_VECTOR;
      req_q    <= 1'b0;
      ce_q     <= 1'b0;
      ifpc_q   <= '0;
      ifinst_q <= '0;
      ifv_q    <= 1'b0;
      pend_q   <= 1'b0;
      tgt_q    <= '0;
      buf_q    <= '0;
      bufv_q   <= 1'b0;
`ifdef FETCH_TIMEOUT_EN
      cnt_q    <= '0;
      err_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      req_q    <= req_d;
      ce_q     <= ce_d;
      ifpc_q   <= ifpc_d;
      ifinst_q <= ifinst_d;
      ifv_q    <= ifv_d;
      pend_q   <= pend_d;
      tgt_q    <= tgt_d;
      buf_q    <= buf_d;
      bufv_q   <= bufv_d;
`ifdef FETCH_TIMEOUT_EN
      cnt_q    <= cnt_d;
      err_q    <= err_d;
`endif
    end
  end

  assign imem.imem_req  = req_q;
  assign imem.imem_addr = pc_q;
  assign ce             = ce_q;
  assign if_pc          = ifpc_q;
  assign if_inst        = ifinst_q;
  assign if_valid       = ifv_q;
`ifdef FETCH_TIMEOUT_EN
  assign fetch_err      = err_q;
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// Scoreboard bench for fetch_ctrl: expected fetch PCs are queued as stimulus is driven and
// popped on each if_valid; a second instance exercises PC wrap-around.
module tb_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        branch_flag;
  logic [31:0] branch_target;
  logic        ce, ce2;
  logic [31:0] if_pc, if_inst, if_pc2, if_inst2;
  logic        if_valid, if_valid2;
`ifdef FETCH_TIMEOUT_EN
  logic        fetch_err, fetch_err2;
`endif

  fetch_ctrl_if bus ();
  fetch_ctrl_if bus2 ();

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] q[$];
  logic [31:0] q2[$];

  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h1234_5678;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, obs, exp_v);
    end
  endtask

  fetch_ctrl #(.RESET_VECTOR(32'h0000_0000), .TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst(rst), .stall(stall), .branch_flag(branch_flag),
    .branch_target(branch_target), .imem(bus.master), .ce(ce),
    .if_pc(if_pc), .if_inst(if_inst), .if_valid(if_valid)
`ifdef FETCH_TIMEOUT_EN
    , .fetch_err(fetch_err)
`endif
  );

  fetch_ctrl #(.RESET_VECTOR(32'hFFFF_FFF8), .TIMEOUT_CYCLES(4)) dut2 (
    .clk(clk), .rst(rst), .stall(1'b0), .branch_flag(1'b0),
    .branch_target(32'h0), .imem(bus2.master), .ce(ce2),
    .if_pc(if_pc2), .if_inst(if_inst2), .if_valid(if_valid2)
`ifdef FETCH_TIMEOUT_EN
    , .fetch_err(fetch_err2)
`endif
  );

  // memory models: main one has programmable wait states, second is zero-wait
  logic        mem_on, mem2_on;
  int unsigned wait_n;
  int unsigned mcnt;
  assign bus.imem_ack    = mem_on && bus.imem_req && (mcnt >= wait_n);
  assign bus.imem_rdata  = inst_of(bus.imem_addr);
  assign bus2.imem_ack   = mem2_on && bus2.imem_req;
  assign bus2.imem_rdata = inst_of(bus2.imem_addr);

  always @(posedge clk) begin
    if (!mem_on || !bus.imem_req || bus.imem_ack) mcnt <= 0;
    else mcnt <= mcnt + 1;
  end

  always @(negedge clk) begin
    if (rst && if_valid) begin
      if (q.size() == 0) chk("spurious_valid", {31'b0, if_valid}, 32'd0);
      else begin
        logic [31:0] e;
        e = q.pop_front();
        chk("if_pc", if_pc, e);
        chk("if_inst", if_inst, inst_of(e));
      end
    end
  end

  always @(negedge clk) begin
    if (rst && if_valid2) begin
      if (q2.size() == 0) chk("spurious_valid2", {31'b0, if_valid2}, 32'd0);
      else begin
        logic [31:0] e;
        e = q2.pop_front();
        chk("if_pc2", if_pc2, e);
        chk("if_inst2", if_inst2, inst_of(e));
      end
    end
  end

  task automatic do_reset();
    rst = 1'b0; mem_on = 1'b0; mem2_on = 1'b0; stall = 1'b0;
    branch_flag = 1'b0; branch_target = '0; wait_n = 0;
    q.delete(); q2.delete();
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic wait_addr(input logic [31:0] a);
    bit hit = 1'b0;
    for (int i = 0; i < 100 && !hit; i++) begin
      @(negedge clk); #1;
      if (bus.imem_req && bus.imem_addr == a) hit = 1'b1;
    end
    if (!hit) chk("wait_addr_timeout", bus.imem_addr, a);
  endtask

  task automatic drain();
    for (int i = 0; i < 200 && q.size() != 0; i++) begin
      @(negedge clk); #1;
    end
    chk("drain", q.size(), 32'd0);
  endtask

  task automatic drain2();
    for (int i = 0; i < 200 && q2.size() != 0; i++) begin
      @(negedge clk); #1;
    end
    chk("drain2", q2.size(), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // reset state
    rst = 1'b0; mem_on = 1'b0; mem2_on = 1'b0; stall = 1'b0;
    branch_flag = 1'b0; branch_target = '0; wait_n = 0;
    repeat (3) @(negedge clk);
    chk("rst_req", {31'b0, bus.imem_req}, 32'd0);
    chk("rst_addr", bus.imem_addr, 32'h0);
    chk("rst_ce", {31'b0, ce}, 32'd0);
    chk("rst_valid", {31'b0, if_valid}, 32'd0);
    chk("rst_if_pc", if_pc, 32'h0);
    chk("rst_if_inst", if_inst, 32'h0);
    chk("rst_addr2", bus2.imem_addr, 32'hFFFF_FFF8);

    // zero-wait streaming
    for (int i = 0; i < 8; i++) q.push_back(32'(4 * i));
    mem_on = 1'b1;
    rst = 1'b1;
    @(negedge clk);
    chk("start_ce", {31'b0, ce}, 32'd1);
    chk("start_req", {31'b0, bus.imem_req}, 32'd1);
    chk("start_valid", {31'b0, if_valid}, 32'd0);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("stream_valid", {31'b0, if_valid}, 32'd1);
    end
    #1 mem_on = 1'b0;
    drain();

    // 3-cycle ack latency
    do_reset();
    wait_n = 2; mem_on = 1'b1;
    q.push_back(32'h0); q.push_back(32'h4); q.push_back(32'h8);
    for (int j = 1; j <= 10; j++) begin
      @(negedge clk);
      chk("lat_valid", {31'b0, if_valid}, (j == 4 || j == 7 || j == 10) ? 32'd1 : 32'd0);
      chk("lat_addr", bus.imem_addr, 32'(4 * ((j - 1) / 3)));
    end
    #1 mem_on = 1'b0;
    drain();

    // stall at ack of 0x8
    do_reset();
    mem_on = 1'b1;
    q.push_back(32'h0); q.push_back(32'h4);
    wait_addr(32'h8);
    stall = 1'b1;
    for (int j = 0; j < 4; j++) begin
      @(negedge clk);
      chk("stall_req", {31'b0, bus.imem_req}, 32'd0);
      chk("stall_valid", {31'b0, if_valid}, 32'd0);
    end
    #1 stall = 1'b0;
    q.push_back(32'h8); q.push_back(32'hC);
    @(negedge clk);
    chk("unstall_valid", {31'b0, if_valid}, 32'd1);
    chk("unstall_req", {31'b0, bus.imem_req}, 32'd1);
    chk("unstall_addr", bus.imem_addr, 32'hC);
    @(negedge clk); #1 mem_on = 1'b0;
    drain();

    // branch while 0x10 outstanding
    do_reset();
    mem_on = 1'b1;
    q.push_back(32'h0); q.push_back(32'h4); q.push_back(32'h8); q.push_back(32'hC);
    wait_addr(32'h10);
    mem_on = 1'b0; branch_flag = 1'b1; branch_target = 32'h103;
    @(negedge clk); #1;
    branch_flag = 1'b0;
    chk("pend_addr", bus.imem_addr, 32'h10);
    chk("pend_req", {31'b0, bus.imem_req}, 32'd1);
    wait_n = 1; mem_on = 1'b1;
    q.push_back(32'h100); q.push_back(32'h104);
    wait_addr(32'h100);
    drain();
    mem_on = 1'b0;

    // branch coinciding with ack
    wait_n = 0; mem_on = 1'b1; branch_flag = 1'b1; branch_target = 32'h20E;
    q.push_back(32'h20C); q.push_back(32'h210);
    @(negedge clk); #1;
    branch_flag = 1'b0;
    chk("br_ack_addr", bus.imem_addr, 32'h20C);
    drain();
    mem_on = 1'b0;

    // branch while holding a buffered instruction
    mem_on = 1'b1; stall = 1'b1;
    @(negedge clk); #1;
    chk("hold_req", {31'b0, bus.imem_req}, 32'd0);
    branch_flag = 1'b1; branch_target = 32'h300;
    @(negedge clk); #1;
    branch_flag = 1'b0; stall = 1'b0;
    chk("hold_br_addr", bus.imem_addr, 32'h300);
    @(negedge clk); #1;
    chk("hold_br_valid", {31'b0, if_valid}, 32'd0);
    chk("hold_br_req", {31'b0, bus.imem_req}, 32'd1);
    chk("hold_br_addr2", bus.imem_addr, 32'h300);
    q.push_back(32'h300);
    drain();
    mem_on = 1'b0;

    // PC wrap-around on the second instance
    do_reset();
    q2.push_back(32'hFFFF_FFF8); q2.push_back(32'hFFFF_FFFC); q2.push_back(32'h0);
    mem2_on = 1'b1;
    drain2();
    mem2_on = 1'b0;
    chk("wrap_next_addr", bus2.imem_addr, 32'h4);

`ifdef FETCH_TIMEOUT_EN
    // ack never arrives: timeout, retry, then async reset mid-request
    do_reset();
    @(negedge clk);
    for (int j = 0; j < 4; j++) begin
      @(negedge clk);
      chk("to_wait_req", {31'b0, bus.imem_req}, 32'd1);
      chk("to_wait_err", {31'b0, fetch_err}, 32'd0);
    end
    @(negedge clk);
    chk("to_err", {31'b0, fetch_err}, 32'd1);
    chk("to_ce", {31'b0, ce}, 32'd0);
    chk("to_req", {31'b0, bus.imem_req}, 32'd0);
    @(negedge clk);
    chk("retry_err", {31'b0, fetch_err}, 32'd0);
    chk("retry_ce", {31'b0, ce}, 32'd1);
    chk("retry_req", {31'b0, bus.imem_req}, 32'd1);
    chk("retry_addr", bus.imem_addr, 32'h0);
    #2 rst = 1'b0;
    #1;
    chk("async_req", {31'b0, bus.imem_req}, 32'd0);
    chk("async_ce", {31'b0, ce}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
